branch_ctrl: RTL and testbench

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_ctrl_pkg.sv | 18 +
 rtl/branch_ctrl_cond_eval.sv | 27 ++
 rtl/branch_ctrl.sv | 102 ++++++++++
 tb/tb_branch_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg: condition codes, FSM state encoding, flag bit indices and flag merge helper
package branch_ctrl_pkg;
  localparam logic [2:0] COND_NE   = 3'd0;
  localparam logic [2:0] COND_EQ   = 3'd1;
  localparam logic [2:0] COND_GT   = 3'd2;
  localparam logic [2:0] COND_LT   = 3'd3;
  localparam logic [2:0] COND_GTE  = 3'd4;
  localparam logic [2:0] COND_LTE  = 3'd5;
  localparam logic [2:0] COND_OVFL = 3'd6;
  localparam logic [2:0] COND_UNC  = 3'd7;
  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, HALT = 2'd2} state_e;
  function automatic logic [2:0] merge_flags(input logic [2:0] old_f, input logic [2:0] we, input logic [2:0] val);
    return (old_f & ~we) | (val & we);
  endfunction
endpackage

// File: rtl/branch_ctrl_cond_eval.sv
// cond_eval: combinational branch condition evaluator
// Ports: cond_i (condition code), flags_i ({N,V,Z}), taken_o (condition holds)
module cond_eval
  import branch_ctrl_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic [2:0] flags_i,
  output logic       taken_o
);
  logic z, v, n;
  assign z = flags_i[FLAG_Z];
  assign v = flags_i[FLAG_V];
  assign n = flags_i[FLAG_N];
  always_comb begin
    taken_o = 1'b1;
    case (cond_i)
      COND_NE:   taken_o = ~z;
      COND_EQ:   taken_o = z;
      COND_GT:   taken_o = ~z & ~n;
      COND_LT:   taken_o = n;
      COND_GTE:  taken_o = z | ~n;
      COND_LTE:  taken_o = n | z;
      COND_OVFL: taken_o = v;
      default:   taken_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: EX-stage branch resolution, flag register, redirect/flush/halt control
// Ports: clk, rst_n (async active-low); ex_valid, stall_i, ex_is_br, ex_is_hlt, ex_cond,
//   ex_flag_we, alu_v/alu_z/alu_n, br_addr (EX instruction); flags_o {N,V,Z}, redirect_o,
//   target_o, flush_o, halt_o.
// Option: BRANCH_CTRL_FLAG_BYPASS_EN commits flags one cycle late and bypasses the pending write.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int FLUSH_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        stall_i,
  input  logic        ex_is_br,
  input  logic        ex_is_hlt,
  input  logic [2:0]  ex_cond,
  input  logic [2:0]  ex_flag_we,
  input  logic        alu_v,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic [15:0] br_addr,
  output logic [2:0]  flags_o,
  output logic        redirect_o,
  output logic [15:0] target_o,
  output logic        flush_o,
  output logic        halt_o
);
  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYC - 1);
  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  flags_q, flags_d;
  logic [15:0] target_q, target_d;
  logic        redirect_q, redirect_d;
  logic [2:0]  alu_f, cond_flags;
  logic        retire, flag_wr, taken;
  assign alu_f   = {alu_n, alu_v, alu_z};
  assign retire  = (state_q == RUN) & ex_valid & ~stall_i;
  // branches never write flags, whatever the mask says
  assign flag_wr = retire & ~ex_is_br;
`ifdef BRANCH_CTRL_FLAG_BYPASS_EN
  logic [2:0] pend_we_q, pend_val_q;
  assign cond_flags = merge_flags(flags_q, pend_we_q, pend_val_q);
  assign flags_d    = cond_flags;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_we_q  <= 3'b000;
      pend_val_q <= 3'b000;
    end else begin
      pend_we_q  <= flag_wr ? ex_flag_we : 3'b000;
      pend_val_q <= alu_f;
    end
  end
`else
  assign cond_flags = flags_q;
  assign flags_d    = flag_wr ? merge_flags(flags_q, ex_flag_we, alu_f) : flags_q;
`endif
  cond_eval u_cond (.cond_i(ex_cond), .flags_i(cond_flags), .taken_o(taken));
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    redirect_d = 1'b0;
    case (state_q)
      RUN: begin
        if (retire && ex_is_hlt) begin
          state_d = HALT;
        end else if (retire && ex_is_br && taken) begin
          state_d    = FLUSH;
          cnt_d      = FLUSH_LAST;
          target_d   = br_addr;
          redirect_d = 1'b1;
        end
      end
      FLUSH: begin
        cnt_d   = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
        state_d = (cnt_q == 3'd0) ? RUN : FLUSH;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      cnt_q      <= 3'd0;
      flags_q    <= 3'b000;
      target_q   <= 16'h0000;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flags_q    <= flags_d;
      target_q   <= target_d;
      redirect_q <= redirect_d;
    end
  end
  assign flags_o    = cond_flags;
  assign redirect_o = redirect_q;
  assign target_o   = target_q;
  assign flush_o    = state_q != RUN;
  assign halt_o     = state_q == HALT;
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: three instances (FLUSH_CYC 2,1,7) under directed and random stimulus vs a behavioural model
module tb_branch_ctrl;
  localparam int FC[3] = '{2, 1, 7};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ex_valid, stall_i, ex_is_br, ex_is_hlt, alu_v, alu_z, alu_n;
  logic [2:0] ex_cond, ex_flag_we;
  logic [15:0] br_addr;
  logic [2:0][2:0] flags_w;
  logic [2:0][15:0] target_w;
  logic [2:0] redirect_w, flush_w, halt_w;
  int checks = 0;
  int errors = 0;
  bit run_chk = 0;
  int fl[3];
  bit hl[3], mr[3];
  logic [2:0] mf[3];
  logic [15:0] mt[3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    branch_ctrl #(.FLUSH_CYC(FC[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .stall_i(stall_i), .ex_is_br(ex_is_br),
      .ex_is_hlt(ex_is_hlt), .ex_cond(ex_cond), .ex_flag_we(ex_flag_we), .alu_v(alu_v),
      .alu_z(alu_z), .alu_n(alu_n), .br_addr(br_addr), .flags_o(flags_w[g]),
      .redirect_o(redirect_w[g]), .target_o(target_w[g]), .flush_o(flush_w[g]), .halt_o(halt_w[g])
    );
  end
  task automatic chk(string nm, int k, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d (FLUSH_CYC=%0d): got %h expected %h at %0t", nm, k, FC[k], act, exp, $time);
    end
  endtask
  function automatic bit cond_true(logic [2:0] c, logic [2:0] f);
    bit z, v, n;
    z = f[0];
    v = f[1];
    n = f[2];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      fl[k] = 0;
      hl[k] = 0;
      mr[k] = 0;
      mf[k] = 3'b000;
      mt[k] = 16'h0000;
    end
  endtask
  task automatic model_step();
    logic [2:0] nvz;
    nvz = {alu_n, alu_v, alu_z};
    if (!rst_n) return;
    for (int k = 0; k < 3; k++) begin
      mr[k] = 0;
      if (hl[k]) continue;
      if (fl[k] > 0) begin
        fl[k]--;
        continue;
      end
      if (!ex_valid || stall_i) continue;
      if (!ex_is_br) mf[k] = (mf[k] & ~ex_flag_we) | (nvz & ex_flag_we);
      if (ex_is_hlt) hl[k] = 1;
      else if (ex_is_br && cond_true(ex_cond, mf[k])) begin
        mt[k] = br_addr;
        mr[k] = 1;
        fl[k] = FC[k];
      end
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && run_chk) begin
      for (int k = 0; k < 3; k++) begin
        chk("flags", k, 16'(flags_w[k]), 16'(mf[k]));
        chk("target", k, target_w[k], mt[k]);
        chk("redirect", k, 16'(redirect_w[k]), 16'(mr[k]));
        chk("flush", k, 16'(flush_w[k]), 16'(hl[k] || fl[k] > 0));
        chk("halt", k, 16'(halt_w[k]), 16'(hl[k]));
      end
    end
  end
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  task automatic drv(bit v, bit s, bit b, bit h, logic [2:0] c, logic [2:0] we, logic [2:0] nvz, logic [15:0] a);
    ex_valid = v;
    stall_i = s;
    ex_is_br = b;
    ex_is_hlt = h;
    ex_cond = c;
    ex_flag_we = we;
    {alu_n, alu_v, alu_z} = nvz;
    br_addr = a;
  endtask
  task automatic idle(int n);
    drv(0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 16'h0);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_flags", k, 16'(flags_w[k]), 16'h0);
      chk("rst_target", k, target_w[k], 16'h0);
      chk("rst_redirect", k, 16'(redirect_w[k]), 16'h0);
      chk("rst_flush", k, 16'(flush_w[k]), 16'h0);
      chk("rst_halt", k, 16'(halt_w[k]), 16'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    int w[3];
    bit dn[3];
    drv(0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 16'h0);
    @(negedge clk);
    do_reset();
    run_chk = 1;
    drv(1, 0, 0, 0, 3'd0, 3'b111, 3'b001, 16'h0);
    step();
    chk("sub_flags", 0, 16'(flags_w[0]), 16'h0001);
    drv(1, 0, 1, 0, 3'd1, 3'd0, 3'd0, 16'h0040);
    step();
    chk("eq_redirect", 0, 16'(redirect_w[0]), 16'h1);
    chk("eq_target", 0, target_w[0], 16'h0040);
    w = '{1, 1, 1};
    dn = '{0, 0, 0};
    drv(0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 16'h0);
    step();
    chk("redirect_one_cycle", 0, 16'(redirect_w[0]), 16'h0);
    chk("target_hold", 0, target_w[0], 16'h0040);
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (!dn[k] && flush_w[k]) w[k]++;
        else dn[k] = 1;
      end
      step();
    end
    chk("flush_width", 0, 16'(w[0]), 16'd2);
    chk("flush_width", 1, 16'(w[1]), 16'd1);
    chk("flush_width", 2, 16'(w[2]), 16'd7);
    drv(1, 0, 0, 0, 3'd0, 3'b111, 3'b110, 16'h0);
    step();
    chk("set_f110", 0, 16'(flags_w[0]), 16'h0006);
    drv(1, 0, 0, 0, 3'd0, 3'b001, 3'b110, 16'h0);
    step();
    chk("mask_z_only", 0, 16'(flags_w[0]), 16'h0006);
    drv(1, 1, 1, 0, 3'd3, 3'b111, 3'b000, 16'h1234);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_no_redirect", 0, 16'(redirect_w[0]), 16'h0);
      chk("stall_flags_hold", 0, 16'(flags_w[0]), 16'h0006);
    end
    stall_i = 1'b0;
    step();
    chk("lt_redirect", 0, 16'(redirect_w[0]), 16'h1);
    chk("lt_target", 0, target_w[0], 16'h1234);
    chk("br_no_flag_write", 0, 16'(flags_w[0]), 16'h0006);
    idle(8);
    drv(1, 0, 0, 0, 3'd0, 3'b010, 3'b000, 16'h0);
    step();
    drv(1, 0, 1, 0, 3'd6, 3'd0, 3'd0, 16'hBEEF);
    step();
    chk("ovfl_v0_no_redirect", 0, 16'(redirect_w[0]), 16'h0);
    chk("ovfl_v0_no_flush", 2, 16'(flush_w[2]), 16'h0);
    drv(1, 0, 1, 0, 3'd7, 3'd0, 3'd0, 16'h0ABC);
    step();
    chk("unc_redirect", 0, 16'(redirect_w[0]), 16'h1);
    drv(1, 0, 1, 1, 3'd7, 3'd0, 3'd0, 16'h0DEF);
    step();
    chk("hlt_in_flush1", 0, 16'(halt_w[0]), 16'h0);
    step();
    chk("hlt_in_flush2", 0, 16'(halt_w[0]), 16'h0);
    step();
    chk("hlt_retired", 0, 16'(halt_w[0]), 16'h1);
    chk("hlt_over_br", 0, 16'(redirect_w[0]), 16'h0);
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 1, 0, 3'd7, 3'b111, 3'($urandom), 16'($urandom));
      step();
      chk("halt_held", 0, 16'(halt_w[0]), 16'h1);
      chk("halt_flush", 0, 16'(flush_w[0]), 16'h1);
    end
    do_reset();
    drv(1, 0, 1, 0, 3'd7, 3'd0, 3'd0, 16'h0077);
    step();
    chk("pre_reset_flush", 0, 16'(flush_w[0]), 16'h1);
    drv(0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 16'h0);
    do_reset();
    drv(1, 0, 1, 0, 3'd7, 3'd0, 3'd0, 16'h0055);
    step();
    chk("run_after_reset", 0, 16'(redirect_w[0]), 16'h1);
    chk("run_after_reset_tgt", 0, target_w[0], 16'h0055);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 399) == 0, 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
